// File: rtl/arp_tx.sv
// arp_tx: ARP transmit engine for the MAC TX path.
//
// Chooses between a pending ARP reply (from the ARP receiver) and a pending
// ARP request (from the upper layer). The reply wins if both are pending.
// The block acknowledges the winner and requests the MAC TX scheduler. Once
// the scheduler grants, it streams the 46-byte ARP payload one byte per clock:
// 28 ARP bytes followed by 18 zero pad bytes.
//
// Ports:
//   clk, rst_n                  clock; asynchronous active-low reset
//   local_ip_addr/mac_addr      sender protocol / hardware address (SPA/SHA)
//   arp_reply_req               level request for a reply, held until ack
//   arp_rec_source_ip/mac_addr  target IP/MAC for a reply
//   arp_reply_ack               one-cycle pulse, reply accepted and latched
//   arp_request_req             level request for a request, held until ack
//   arp_request_ip_addr         target IP for a request
//   arp_request_ack             one-cycle pulse, request accepted
//   arp_tx_req / arp_tx_ack     request to / grant from the MAC TX scheduler
//   arp_tx_data/valid/end       payload byte stream, end marks byte 45
//   arp_tx_dest_mac             Ethernet destination for the MAC header
module arp_tx #(
  parameter logic [15:0] ACK_TIMEOUT = 16'd50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] local_ip_addr,
  input  logic [47:0] local_mac_addr,
  input  logic        arp_reply_req,
  input  logic [31:0] arp_rec_source_ip_addr,
  input  logic [47:0] arp_rec_source_mac_addr,
  output logic        arp_reply_ack,
  input  logic        arp_request_req,
  input  logic [31:0] arp_request_ip_addr,
  output logic        arp_request_ack,
  output logic        arp_tx_req,
  input  logic        arp_tx_ack,
  output logic [7:0]  arp_tx_data,
  output logic        arp_tx_valid,
  output logic        arp_tx_end,
  output logic [47:0] arp_tx_dest_mac
);

  typedef enum logic [4:0] {
    IDLE         = 5'b00001,
    ARP_LATCH    = 5'b00010,
    ARP_WAIT_ACK = 5'b00100,
    ARP_SEND     = 5'b01000,
    ARP_END      = 5'b10000
  } state_t;

  localparam logic [7:0] LAST_BYTE = 8'd45;
  localparam logic [7:0] ARP_BYTES = 8'd28;

  state_t      state_reg, state_next;
  logic [7:0]  cnt_reg;
  logic [15:0] wait_cnt_reg;
  logic        op_reply_reg;
  logic [47:0] sha_reg, tha_reg, dest_mac_reg;
  logic [31:0] spa_reg, tpa_reg;
  logic        reply_ack_reg, request_ack_reg, tx_req_reg;
  logic [7:0]  data_reg;
  logic        valid_reg, end_reg;

  logic        wait_expired;
  logic [7:0]  byte_idx;
  logic [7:0]  byte_sel;
  logic [223:0] arp_frame;
  logic [7:0]  frame_bytes [0:31];

  assign wait_expired = (wait_cnt_reg == ACK_TIMEOUT - 16'd1);

  // ARP header and addresses laid out MSB first; byte 0 is the top byte.
  assign arp_frame = {16'h0001, 16'h0800, 8'h06, 8'h04,
                      (op_reply_reg ? 16'h0002 : 16'h0001),
                      sha_reg, spa_reg, tha_reg, tpa_reg};

  // Byte table padded to a power of two so the 5-bit index never leaves it.
  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_bytes
      if (gi < 28) begin : g_arp
        assign frame_bytes[gi] = arp_frame[223 - 8*gi -: 8];
      end else begin : g_pad
        assign frame_bytes[gi] = 8'h00;
      end
    end
  endgenerate

  // Data is registered, so the byte loaded on each edge is the one that
  // cnt_reg will point at after that edge.
  assign byte_idx = (state_reg == ARP_SEND) ? (cnt_reg + 8'd1) : 8'd0;
  assign byte_sel = (byte_idx < ARP_BYTES) ? frame_bytes[byte_idx[4:0]] : 8'h00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE: begin
        if (arp_reply_req || arp_request_req) begin
          state_next = ARP_LATCH;
        end
      end
      ARP_LATCH: begin
        state_next = ARP_WAIT_ACK;
      end
      ARP_WAIT_ACK: begin
        if (arp_tx_ack) begin
          state_next = ARP_SEND;
        end else if (wait_expired) begin
          state_next = IDLE;
        end
      end
      ARP_SEND: begin
        if (cnt_reg == LAST_BYTE) begin
          state_next = ARP_END;
        end
      end
      ARP_END: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg         <= 8'd0;
      wait_cnt_reg    <= 16'd0;
      op_reply_reg    <= 1'b0;
      sha_reg         <= 48'd0;
      spa_reg         <= 32'd0;
      tha_reg         <= 48'd0;
      tpa_reg         <= 32'd0;
      dest_mac_reg    <= 48'd0;
      reply_ack_reg   <= 1'b0;
      request_ack_reg <= 1'b0;
      tx_req_reg      <= 1'b0;
      data_reg        <= 8'd0;
      valid_reg       <= 1'b0;
      end_reg         <= 1'b0;
    end else begin
      reply_ack_reg   <= 1'b0;
      request_ack_reg <= 1'b0;

      if (state_reg == IDLE && state_next == ARP_LATCH) begin
        reply_ack_reg   <= arp_reply_req;
        request_ack_reg <= ~arp_reply_req;
        op_reply_reg    <= arp_reply_req;
        sha_reg         <= local_mac_addr;
        spa_reg         <= local_ip_addr;
        if (arp_reply_req) begin
          tha_reg      <= arp_rec_source_mac_addr;
          tpa_reg      <= arp_rec_source_ip_addr;
          dest_mac_reg <= arp_rec_source_mac_addr;
        end else begin
          tha_reg      <= 48'd0;
          tpa_reg      <= arp_request_ip_addr;
          dest_mac_reg <= 48'hFFFF_FFFF_FFFF;
        end
      end

      tx_req_reg <= (state_next == ARP_WAIT_ACK);

      if (state_reg == ARP_WAIT_ACK && state_next == ARP_WAIT_ACK) begin
        wait_cnt_reg <= wait_cnt_reg + 16'd1;
      end else begin
        wait_cnt_reg <= 16'd0;
      end

      if (state_reg == ARP_WAIT_ACK && state_next == ARP_SEND) begin
        cnt_reg   <= 8'd0;
        data_reg  <= byte_sel;
        valid_reg <= 1'b1;
        end_reg   <= 1'b0;
      end else if (state_reg == ARP_SEND && state_next == ARP_SEND) begin
        cnt_reg   <= cnt_reg + 8'd1;
        data_reg  <= byte_sel;
        valid_reg <= 1'b1;
        end_reg   <= (cnt_reg + 8'd1 == LAST_BYTE);
      end else begin
        cnt_reg   <= 8'd0;
        data_reg  <= 8'd0;
        valid_reg <= 1'b0;
        end_reg   <= 1'b0;
      end
    end
  end

  assign arp_reply_ack   = reply_ack_reg;
  assign arp_request_ack = request_ack_reg;
  assign arp_tx_req      = tx_req_reg;
  assign arp_tx_data     = data_reg;
  assign arp_tx_valid    = valid_reg;
  assign arp_tx_end      = end_reg;
  assign arp_tx_dest_mac = dest_mac_reg;

endmodule

// File: doc/arp_tx.md
# arp_tx

ARP transmit engine in the MAC TX path. Sends either an ARP reply, triggered by `arp_reply_req` from the ARP receiver, or an ARP request for a target IP, triggered by the upper layer. It arbitrates between the two sources, acknowledges the winner, and requests the MAC transmit scheduler. Once granted, it streams the 46-byte ARP payload (28 ARP bytes plus 18 zero pad bytes) one byte per clock. The MAC layer adds the Ethernet header, using the destination MAC that this block supplies.

## Interface

**Parameters**

- `ACK_TIMEOUT`, default 16'd50000: maximum cycles to wait for `arp_tx_ack` before abandoning the frame.

**Ports**

- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `local_ip_addr` in 32: sender protocol address (SPA).
- `local_mac_addr` in 48: sender hardware address (SHA).
- `arp_reply_req` in 1: level from the ARP receiver. Held until `arp_reply_ack`.
- `arp_rec_source_ip_addr` in 32: target IP for a reply.
- `arp_rec_source_mac_addr` in 48: target MAC for a reply.
- `arp_reply_ack` out 1: one-cycle pulse; the reply has been accepted and its fields latched.
- `arp_request_req` in 1: level from the upper layer. Held until `arp_request_ack`.
- `arp_request_ip_addr` in 32: target IP for a request.
- `arp_request_ack` out 1: one-cycle pulse; the request has been accepted.
- `arp_tx_req` out 1: request to the MAC TX scheduler.
- `arp_tx_ack` in 1: grant from the MAC TX scheduler.
- `arp_tx_data` out 8: payload byte.
- `arp_tx_valid` out 1: `arp_tx_data` is valid this cycle.
- `arp_tx_end` out 1: one-cycle pulse coincident with the last byte.
- `arp_tx_dest_mac` out 48: Ethernet destination for the MAC header. Valid from `arp_tx_req` rising until `arp_tx_end`.

## Operation

**States:** IDLE, ARP_LATCH, ARP_WAIT_ACK, ARP_SEND, ARP_END. The encoding is one-hot.

- **IDLE**
  - If `arp_reply_req` is high, go to ARP_LATCH.
  - Otherwise, if `arp_request_req` is high, go to ARP_LATCH.
  - Reply has priority when both are high. The loser stays pending because it is a level.
- **IDLE → ARP_LATCH transition:** on this edge the block
  - latches op, target MAC/IP and `arp_tx_dest_mac`, plus SHA/SPA from the `local_*` inputs;
  - pulses the winning ack for exactly one cycle (the ARP_LATCH cycle).
- **ARP_LATCH:** go to ARP_WAIT_ACK unconditionally.
- **ARP_WAIT_ACK**
  - `arp_tx_req` is high.
  - On `arp_tx_ack`=1, go to ARP_SEND.
  - If the wait counter reaches `ACK_TIMEOUT`-1 without an ack, go to IDLE and drop the frame. No retry is made and no ack is re-issued.
- **ARP_SEND**
  - Byte counter `cnt` (8 bits) runs 0..45.
  - Leave for ARP_END when `cnt`==45.
- **ARP_END:** one cycle, then IDLE. This guarantees at least one IDLE cycle between frames.

**Payload by `cnt`, all multi-byte fields MSB first:**

- 0-1: 0x0001 (htype).
- 2-3: 0x0800 (ptype).
- 4: 0x06.
- 5: 0x04.
- 6-7: op (0x0001 for a request, 0x0002 for a reply).
- 8-13: SHA.
- 14-17: SPA.
- 18-23: THA.
  - Request: 48'h0.
  - Reply: latched `arp_rec_source_mac_addr`.
- 24-27: TPA.
  - Request: latched `arp_request_ip_addr`.
  - Reply: latched `arp_rec_source_ip_addr`.
- 28-45: 0x00.

**`arp_tx_dest_mac`:**

- Request: 48'hFFFF_FFFF_FFFF.
- Reply: latched `arp_rec_source_mac_addr`.

**Latching:** changes on the `*_addr` inputs after latching have no effect on the frame in progress.

## Timing

**Reset values:** every output is 0, including `arp_tx_dest_mac`; state is IDLE and counters are 0.

**Asserting reset mid-frame:**

- Immediately aborts the frame.
- Forces `arp_tx_valid` and `arp_tx_req` to 0.
- No `arp_tx_end` is produced.

**Handshake with the MAC scheduler:**

- `arp_tx_req` is registered and rises in the first ARP_WAIT_ACK cycle, which is 2 cycles after the source request is sampled in IDLE.
- It falls on the edge that samples `arp_tx_ack`=1.

**Data stream:**

- `arp_tx_data`/`arp_tx_valid` are registered.
- Byte 0 is presented in the cycle after the edge that samples the ack.
- 46 consecutive valid cycles follow, with no gaps.
- `arp_tx_end`=1 with byte 45 only.

**Ack pulses:**

- `arp_reply_ack` and `arp_request_ack` are each high for exactly 1 cycle per accepted frame.
- They are never high together.

**Wait counter:**

- 16 bits.
- Cleared outside ARP_WAIT_ACK.
- On timeout, `arp_tx_req` drops in the following cycle.

**Sources during a frame:** requests asserted during ARP_SEND/ARP_END are not acked until the next IDLE cycle.

**Latency:** source request in IDLE to byte 0 is 3 cycles plus the scheduler grant delay.

## Test plan

- **Reply:** `local_ip`=192.168.0.2, `local_mac`=00:0A:35:01:FE:C0, `rec_source` 192.168.0.3 / 11:22:33:44:55:66, `arp_reply_req`=1.
  - `arp_reply_ack` pulses once; `arp_tx_dest_mac`=11:22:33:44:55:66.
  - After ack, 46 bytes stream: 00 01 08 00 06 04 00 02 00 0A 35 01 FE C0 C0 A8 00 02 11 22 33 44 55 66 C0 A8 00 03, then 18×00.
  - `arp_tx_end` is high only with byte 45.
- **Request:** `arp_request_ip`=192.168.0.9.
  - op bytes are 00 01; THA is 6×00; TPA is C0 A8 00 09.
  - `arp_tx_dest_mac`=FF:FF:FF:FF:FF:FF.
- **Simultaneous requests:** reply and request asserted in the same cycle.
  - Reply frame is sent first with `arp_reply_ack` only.
  - After ARP_END plus 1 IDLE cycle, the request frame follows with `arp_request_ack`.
- **Grant delay:** `arp_tx_ack` withheld for 20 cycles.
  - `arp_tx_req` stays high for 20 cycles and `arp_tx_valid` stays 0.
  - After ack, the stream is intact.
- **Timeout:** `ACK_TIMEOUT`=8 and no ack.
  - `arp_tx_req` is high for 8 cycles, then 0, then the block returns to IDLE.
  - No `arp_tx_valid`, no `arp_tx_end`; a later request is served normally.
- **Reset mid-frame:** `rst_n` pulsed low at byte 20.
  - All outputs go to 0 immediately and no `arp_tx_end` is produced.
  - A pending `arp_reply_req` is re-served from IDLE after reset is released.
